// File: rtl/prog_loader.sv
// Program-image loader: accepts [LEN][data...][CSUM] and writes the data into CPU program memory.
// Latency: one cycle from byte acceptance to mem_wr; status outputs follow the accepting cycle by one.
// Backpressure: in_ready is high only while a load is in progress; an idle gap of TIMEOUT cycles aborts it.
module prog_loader #(
    parameter int AWIDTH    = 5,
    parameter int DWIDTH    = 8,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_data,
    output logic              mem_wr,
    output logic              cpu_rst_,
    output logic              done,
    output logic              error
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int LW    = ((DWIDTH > AWIDTH) ? DWIDTH : AWIDTH) + 1;
    localparam logic [AWIDTH-1:0] BASE      = AWIDTH'(BASE_ADDR);
    localparam logic [TW-1:0]     TIMER_MAX = TW'(TIMEOUT - 1);
    localparam logic [LW-1:0]     DEPTH_W   = LW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_nxt;
    logic [DWIDTH-1:0] count, count_nxt;
    logic [DWIDTH-1:0] idx, idx_nxt;
    logic [DWIDTH-1:0] sum, sum_nxt;
    logic [AWIDTH-1:0] ptr, ptr_nxt;
    logic [TW-1:0]     timer, timer_nxt;
    logic [AWIDTH-1:0] addr_nxt;
    logic [DWIDTH-1:0] data_nxt;
    logic              wr_nxt;
    logic              xfer;

    assign xfer = in_valid & in_ready;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        idx_nxt   = idx;
        sum_nxt   = sum;
        ptr_nxt   = ptr;
        timer_nxt = timer;
        addr_nxt  = mem_addr;
        data_nxt  = mem_data;
        wr_nxt    = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt = S_LEN;
                    sum_nxt   = '0;
                    idx_nxt   = '0;
                    timer_nxt = '0;
                    ptr_nxt   = BASE;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    if (in_data == '0 || LW'(in_data) > DEPTH_W) begin
                        state_nxt = S_ERR;
                    end else begin
                        count_nxt = in_data;
                        sum_nxt   = in_data;
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    wr_nxt   = 1'b1;
                    addr_nxt = ptr;
                    data_nxt = in_data;
                    ptr_nxt  = ptr + 1'b1;
                    sum_nxt  = sum + in_data;
                    idx_nxt  = idx + 1'b1;
                    if (idx == count - 1'b1) begin
                        state_nxt = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_nxt = (in_data == sum) ? S_DONE : S_ERR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Idle-gap watchdog; an accepted byte always wins over an expiring timer.
        if (in_ready) begin
            if (xfer) begin
                timer_nxt = '0;
            end else if (timer == TIMER_MAX) begin
                state_nxt = S_ERR;
            end else begin
                timer_nxt = timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= S_IDLE;
            count    <= '0;
            idx      <= '0;
            sum      <= '0;
            ptr      <= '0;
            timer    <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_wr   <= 1'b0;
            in_ready <= 1'b0;
            cpu_rst_ <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            idx      <= idx_nxt;
            sum      <= sum_nxt;
            ptr      <= ptr_nxt;
            timer    <= timer_nxt;
            mem_addr <= addr_nxt;
            mem_data <= data_nxt;
            mem_wr   <= wr_nxt;
            // Status flops track the next state so they line up with the state register.
            in_ready <= (state_nxt == S_LEN) || (state_nxt == S_DATA) || (state_nxt == S_CSUM);
            cpu_rst_ <= (state_nxt == S_DONE);
            done     <= (state_nxt == S_DONE);
            error    <= (state_nxt == S_ERR);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader with BASE_ADDR=30 and TIMEOUT=8; writes and load outcomes go through scoreboard queues.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst_;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_wr;
    logic       cpu_rst_;
    logic       done;
    logic       error;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wq[$];
    logic [2:0] sq[$];
    logic [7:0] img[$];
    logic       term_q = 1'b0;

    prog_loader #(
        .AWIDTH   (5),
        .DWIDTH   (8),
        .BASE_ADDR(30),
        .TIMEOUT  (8)
    ) u_dut (
        .clk     (clk),
        .rst_    (rst_),
        .start   (start),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_wr  (mem_wr),
        .cpu_rst_(cpu_rst_),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe and every rising done/error is matched against the queues.
    always @(negedge clk) begin
        if (!rst_) begin
            term_q = 1'b0;
        end else begin
            if (mem_wr) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_data);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("mem_write", {mem_addr, mem_data}, {w.a, w.d});
                end
            end
            if ((done || error) && !term_q) begin
                if (sq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_status: got done=%0b error=%0b expected none", done, error);
                end else begin
                    logic [2:0] s;
                    s = sq.pop_front();
                    check("load_status", {done, error, cpu_rst_}, s);
                end
            end
            term_q = done || error;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // All driver tasks start and end on a falling edge.
    task automatic send(input logic [7:0] b);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_ready: got in_ready=0 for 20 cycles expected 1");
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_img();
        foreach (img[i]) send(img[i]);
        idle();
    endtask

    // Expected writes for the first n data bytes of img, starting at address 30 and wrapping at 32.
    task automatic push_writes(input int n);
        for (int k = 0; k < n; k++) begin
            wr_t w;
            w.a = 5'((30 + k) % 32);
            w.d = img[k + 1];
            wq.push_back(w);
        end
    endtask

    initial begin
        rst_     = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", {in_ready, mem_wr, mem_addr, mem_data, cpu_rst_, done, error}, 18'h0);
        rst_ = 1'b1;
        @(negedge clk);
        check("idle_not_ready", in_ready, 1'b0);

        // Good image (byte sum including LEN is 0x19), with a 7-cycle gap that must not time out.
        img = {8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h19};
        push_writes(3);
        sq.push_back(3'b101);
        do_start();
        check("len_ready", in_ready, 1'b1);
        send(8'h03);
        send(8'hA1);
        idle();
        repeat (7) @(negedge clk);
        send(8'hB2);
        send(8'hC3);
        send(8'h19);
        idle();
        repeat (2) @(negedge clk);
        check("done_not_ready", in_ready, 1'b0);

        // Same image, bad checksum; restart from DONE drops cpu_rst_ right away.
        img = {8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h00};
        push_writes(3);
        sq.push_back(3'b010);
        do_start();
        check("restart_cpu_rst", {cpu_rst_, done, mem_wr}, 3'b000);
        run_img();
        repeat (2) @(negedge clk);

        // Wrapping addresses 30,31,0,1.
        img = {8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E};
        push_writes(4);
        sq.push_back(3'b101);
        do_start();
        run_img();
        repeat (2) @(negedge clk);

        // Illegal lengths.
        img = {8'h00};
        sq.push_back(3'b010);
        do_start();
        run_img();
        repeat (2) @(negedge clk);
        img = {8'h21};
        sq.push_back(3'b010);
        do_start();
        run_img();
        repeat (2) @(negedge clk);

        // Full-depth load: 32 bytes 0..31, checksum 0x20 + 496 = 0x10.
        img = {8'h20};
        for (int k = 0; k < 32; k++) img.push_back(8'(k));
        img.push_back(8'h10);
        push_writes(32);
        sq.push_back(3'b101);
        do_start();
        run_img();
        repeat (2) @(negedge clk);

        // Stall 8 cycles after the second data byte.
        img = {8'h04, 8'h01, 8'h02};
        push_writes(2);
        sq.push_back(3'b010);
        do_start();
        run_img();
        repeat (7) @(negedge clk);
        check("no_early_timeout", error, 1'b0);
        repeat (3) @(negedge clk);
        img = {8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E};
        push_writes(4);
        sq.push_back(3'b101);
        do_start();
        run_img();
        repeat (2) @(negedge clk);

        // Reset in the middle of DATA.
        img = {8'h04, 8'h01, 8'h02};
        push_writes(2);
        do_start();
        run_img();
        @(negedge clk);
        #2 rst_ = 1'b0;
        #1 check("async_reset_outputs", {in_ready, mem_wr, mem_addr, mem_data, cpu_rst_, done, error}, 18'h0);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {in_ready, done, error}, 3'b000);

        // start while loading must be ignored, both in LEN and mid-DATA.
        img = {8'h02, 8'h55, 8'h66, 8'hBD};
        push_writes(2);
        sq.push_back(3'b101);
        do_start();
        check("reload_ready", in_ready, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(8'h02);
        start = 1'b1;
        send(8'h55);
        start = 1'b0;
        send(8'h66);
        send(8'hBD);
        idle();
        repeat (3) @(negedge clk);
        check("final_cpu_rst", cpu_rst_, 1'b1);

        check("writes_drained", 32'(wq.size()), 32'd0);
        check("status_drained", 32'(sq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
